// File: rtl/capture_readout_pkg.sv
// capture_readout_pkg: FSM encodings, header sync byte and bytes-per-word helper
// shared by the capture readout design.
package capture_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int bytes_per_word(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/capture_readout_if.sv
// capture_readout_if: memory read port plus outgoing valid/ready byte stream.
interface capture_readout_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] o_raddr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic [7:0]            o_byte;
    logic                  o_byte_valid;
    logic                  i_byte_ready;

    modport master (
        output o_raddr, o_byte, o_byte_valid,
        input  i_rdata, i_byte_ready
    );

    modport slave (
        input  o_raddr, o_byte, o_byte_valid,
        output i_rdata, i_byte_ready
    );
endinterface

// File: rtl/capture_readout_word_serializer.sv
// capture_readout_word_serializer: loads one word and emits it MSB byte first
// over valid/ready, flagging when the last byte is accepted.
module capture_readout_word_serializer
    import capture_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    output logic                  o_last
);
    localparam int B  = bytes_per_word(DATA_WIDTH);
    localparam int W  = 8 * B;
    localparam int CW = $clog2(B + 1);

    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          fire;

    assign fire    = valid_q & i_ready;
    assign o_last  = fire && cnt_q == CW'(1);
    assign o_valid = valid_q;
    assign o_byte  = sr_q[W-1 -: 8];

    // Zero-extension on load pads the top byte when DATA_WIDTH is not a byte multiple.
    always_comb begin
        sr_d    = i_load ? W'(i_word) : fire ? sr_q << 8 : sr_q;
        cnt_d   = i_load ? CW'(B) : fire ? cnt_q - CW'(1) : cnt_q;
        valid_d = i_load | (valid_q & ~o_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/capture_readout.sv
// capture_readout: streams the capture buffer oldest-first as bytes over valid/ready.
// Define READOUT_HEADER_EN to prefix the data with A5 and a 16-bit word count.
module capture_readout
    import capture_readout_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_stopped,
    input  logic                  i_primed,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    capture_readout_if.master     bus,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic                  stopped_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  start, load, ser_valid, ser_last;
    logic [7:0]            ser_byte;

    assign start       = i_stopped & ~stopped_q;
    assign bus.o_raddr = addr_q;
    assign o_busy      = state_q != S_IDLE && state_q != S_DONE;
    assign o_done      = state_q == S_DONE;

`ifdef READOUT_HEADER_EN
    logic [1:0]  hidx_q, hidx_d;
    logic [15:0] count16;
    logic        hdr_fire;

    assign count16          = 16'(count_q);
    assign hdr_fire         = state_q == S_HDR && bus.i_byte_ready;
    assign bus.o_byte_valid = ser_valid | (state_q == S_HDR);
    assign bus.o_byte       = state_q != S_HDR ? ser_byte :
                              hidx_q == 2'd0   ? SYNC_BYTE :
                              hidx_q == 2'd1   ? count16[15:8] : count16[7:0];

    always_comb hidx_d = !hdr_fire ? hidx_q : hidx_q == 2'd2 ? 2'd0 : hidx_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hidx_q <= 2'd0;
        else       hidx_q <= hidx_d;
    end
`else
    assign bus.o_byte_valid = ser_valid;
    assign bus.o_byte       = ser_byte;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                // Primed: the oldest sample sits at the write pointer and the whole ring is valid.
                addr_d  = i_primed ? i_waddr : '0;
                count_d = i_primed ? FULL_COUNT : {1'b0, i_waddr};
`ifdef READOUT_HEADER_EN
                state_d = S_HDR;
`else
                state_d = count_d == '0 ? S_DONE : S_FETCH;
`endif
            end
`ifdef READOUT_HEADER_EN
            S_HDR: if (hdr_fire && hidx_q == 2'd2) state_d = count_q == '0 ? S_DONE : S_FETCH;
`endif
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                load    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: if (ser_last) begin
                count_d = count_q - (ADDR_WIDTH+1)'(1);
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = count_q == (ADDR_WIDTH+1)'(1) ? S_DONE : S_FETCH;
            end
            S_DONE: if (!i_stopped) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stopped_q <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            stopped_q <= i_stopped;
            addr_q    <= addr_d;
            count_q   <= count_d;
        end
    end

    capture_readout_word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .i_load  (load),
        .i_word  (bus.i_rdata),
        .i_ready (bus.i_byte_ready),
        .o_byte  (ser_byte),
        .o_valid (ser_valid),
        .o_last  (ser_last)
    );
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: table-driven readouts of a 16-deep, 32-bit buffer checked against a
// byte scoreboard, plus mid-readout reset and a 12-bit data width instance.
module tb_capture_readout;
`ifdef READOUT_HEADER_EN
    localparam bit HAS_HDR = 1'b1;
`else
    localparam bit HAS_HDR = 1'b0;
`endif

    typedef struct {
        string      name;
        bit         primed;
        logic [3:0] waddr;
        bit         fill;
        bit         rnd;
        int         words;
    } rec_t;

    logic clk = 1'b0, reset = 1'b1;
    logic st32 = 1'b0, pr32 = 1'b0;
    logic [3:0] wa32 = '0;
    logic busy32, done32;
    logic st12 = 1'b0, pr12 = 1'b0;
    logic [1:0] wa12 = '0;
    logic busy12, done12;

    logic [31:0] mem32 [16];
    logic [11:0] mem12 [4];
    logic [31:0] pat [3];
    logic [7:0]  sb [$];
    rec_t        recs [7];

    int  errors = 0, checks = 0, cyc = 0;
    int  nbytes, first_valid, ref_cyc, start_cyc;
    bit  rnd = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_byte;

    capture_readout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus32 ();
    capture_readout_if #(.DATA_WIDTH(12), .ADDR_WIDTH(2)) bus12 ();

    capture_readout #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut32 (
        .clk(clk), .reset(reset), .i_stopped(st32), .i_primed(pr32), .i_waddr(wa32),
        .bus(bus32), .o_busy(busy32), .o_done(done32)
    );

    capture_readout #(.DATA_WIDTH(12), .ADDR_WIDTH(2)) dut12 (
        .clk(clk), .reset(reset), .i_stopped(st12), .i_primed(pr12), .i_waddr(wa12),
        .bus(bus12), .o_busy(busy12), .o_done(done12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) bus32.i_rdata <= mem32[bus32.o_raddr];
    always @(posedge clk) bus12.i_rdata <= mem12[bus12.o_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(bus32.o_byte_valid), 32'd1);
                chk("hold_byte", 32'(bus32.o_byte), 32'(prev_byte));
            end
            if (bus32.o_byte_valid && first_valid < 0) first_valid = cyc;
            if (bus32.o_byte_valid && bus32.i_byte_ready) begin
                nbytes++;
                ref_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", bus32.o_byte);
                end else chk("byte", 32'(bus32.o_byte), 32'(sb.pop_front()));
            end
            prev_stall = bus32.o_byte_valid & ~bus32.i_byte_ready;
            prev_byte  = bus32.o_byte;
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk);
            #1;
            bus32.i_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic setup_rec(input rec_t r);
        int st, cnt;
        logic [31:0] w;
        for (int k = 0; k < 16; k++) mem32[k] = r.fill ? 32'(k) : (k < 3 ? pat[k] : 32'hDEAD_0000 | 32'(k));
        st32 = 1'b0;
        repeat (2) @(negedge clk);
        pr32 = r.primed;
        wa32 = r.waddr;
        rnd  = r.rnd;
        st  = r.primed ? int'(r.waddr) : 0;
        cnt = r.primed ? 16 : int'(r.waddr);
        if (HAS_HDR) begin
            sb.push_back(8'hA5);
            sb.push_back(8'(cnt >> 8));
            sb.push_back(8'(cnt));
        end
        for (int i = 0; i < cnt; i++) begin
            w = mem32[(st + i) % 16];
            for (int b = 3; b >= 0; b--) sb.push_back(w[8*b +: 8]);
        end
        nbytes      = 0;
        first_valid = -1;
        ref_cyc     = cyc;
        start_cyc   = cyc;
        st32        = 1'b1;
    endtask

    task automatic run_rec(input rec_t r);
        int exp_n, dcyc;
        setup_rec(r);
        exp_n = r.words * 4 + (HAS_HDR ? 3 : 0);
        dcyc  = -1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done32) begin
                dcyc = cyc;
                break;
            end
        end
        chk({r.name, "_done"}, 32'(done32), 32'd1);
        chk({r.name, "_done_lat"}, 32'(dcyc), 32'(ref_cyc + 1));
        chk({r.name, "_nbytes"}, 32'(nbytes), 32'(exp_n));
        chk({r.name, "_sb_left"}, 32'(sb.size()), 32'd0);
        chk({r.name, "_busy"}, 32'(busy32), 32'd0);
        if (exp_n > 0) chk({r.name, "_first_lat"}, 32'(first_valid - start_cyc), HAS_HDR ? 32'd1 : 32'd3);
        repeat (3) @(negedge clk);
        chk({r.name, "_done_hold"}, 32'(done32), 32'd1);
        st32 = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk({r.name, "_done_clr"}, 32'(done32), 32'd0);
    endtask

    initial begin
        logic [7:0] got [$];
        logic [7:0] exp12 [$];
        pat = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        recs[0] = '{"unprimed3", 1'b0, 4'd3,  1'b0, 1'b0, 3};
        recs[1] = '{"primed14",  1'b1, 4'd14, 1'b1, 1'b0, 16};
        recs[2] = '{"stall_unp", 1'b0, 4'd3,  1'b0, 1'b1, 3};
        recs[3] = '{"stall_prm", 1'b1, 4'd14, 1'b1, 1'b1, 16};
        recs[4] = '{"empty",     1'b0, 4'd0,  1'b0, 1'b0, 0};
        recs[5] = '{"primed0",   1'b1, 4'd0,  1'b1, 1'b1, 16};
        recs[6] = '{"unprim15",  1'b0, 4'd15, 1'b1, 1'b1, 15};
        for (int k = 0; k < 16; k++) mem32[k] = '0;
        for (int k = 0; k < 4; k++) mem12[k] = '0;
        bus32.i_byte_ready = 1'b1;
        bus12.i_byte_ready = 1'b1;
        fork
            monitor();
            drive_ready();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_raddr", 32'(bus32.o_raddr), 32'd0);
        chk("rst_byte", 32'(bus32.o_byte), 32'd0);
        chk("rst_valid", 32'(bus32.o_byte_valid), 32'd0);
        chk("rst_busy", 32'(busy32), 32'd0);
        chk("rst_done", 32'(done32), 32'd0);
        chk("rst12_valid", 32'(bus12.o_byte_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_rec(recs[i]);

        // Reset in the middle of the second word, then a fresh edge restarts from the oldest word.
        setup_rec(recs[1]);
        for (int k = 0; k < 200 && nbytes < 6; k++) @(negedge clk);
        chk("mid_reached", 32'(nbytes >= 6), 32'd1);
        chk("mid_valid_pre", 32'(bus32.o_byte_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_raddr", 32'(bus32.o_raddr), 32'd0);
        chk("mid_rst_byte", 32'(bus32.o_byte), 32'd0);
        chk("mid_rst_valid", 32'(bus32.o_byte_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy32), 32'd0);
        chk("mid_rst_done", 32'(done32), 32'd0);
        sb.delete();
        st32 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_rec(recs[1]);

        // 12-bit words: top byte zero-padded.
        mem12[0] = 12'hABC;
        mem12[1] = 12'h123;
        if (HAS_HDR) exp12 = '{8'hA5, 8'h00, 8'h02};
        exp12.push_back(8'h0A);
        exp12.push_back(8'hBC);
        exp12.push_back(8'h01);
        exp12.push_back(8'h23);
        wa12 = 2'd2;
        st12 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus12.o_byte_valid && bus12.i_byte_ready) got.push_back(bus12.o_byte);
            if (done12) break;
        end
        chk("dw12_done", 32'(done12), 32'd1);
        chk("dw12_count", 32'(got.size()), 32'(exp12.size()));
        for (int i = 0; i < exp12.size(); i++)
            chk("dw12_byte", i < got.size() ? 32'(got[i]) : 32'hFFFF, 32'(exp12[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
